// File: rtl/sisc_fetch_unit.sv
// SISC instruction-fetch datapath: PC, IR and a req/valid fetch handshake with stall reporting.
// Optional SISC_BRANCH_COUNT_EN adds saturating taken-branch and fetch counters.
module sisc_fetch_unit #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  output logic               fetch_stall,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [15:0]        imm
`ifdef SISC_BRANCH_COUNT_EN
  ,
  output logic [15:0]        br_taken_cnt,
  output logic [15:0]        fetch_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    imm_zext;
  logic [PC_W-1:0]    imm_sext;
  logic [PC_W-1:0]    br_target;
  logic [15:0]        imm_w;
  logic               capture;
  logic               br_upd;

  assign imm_w = ir_q[15:0];

  // Capture is the only way out of WAIT; pc_rst overrides any pending fetch.
  assign capture = !pc_rst && imem_valid &&
                   ((state_q == ST_IDLE && ir_load) || state_q == ST_WAIT);
  assign br_upd  = !pc_rst && (state_q == ST_IDLE) && !ir_load && pc_write && pc_sel;

  always_comb begin
    imm_zext = '0;
    imm_sext = '0;
    for (int i = 0; i < PC_W; i++) begin
      imm_zext[i] = (i < 16) ? imm_w[i[3:0]] : 1'b0;
      imm_sext[i] = (i < 16) ? imm_w[i[3:0]] : imm_w[15];
    end
    pc_inc    = pc_q + PC_W'(1);
    br_target = br_sel ? imm_zext : (pc_q + imm_sext);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    if (pc_rst) begin
      state_d = ST_IDLE;
      pc_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ir_load) begin
            // A concurrent pc_write increment is the same increment as the fetch.
            if (imem_valid) begin
              ir_d = imem_rdata;
              pc_d = pc_inc;
            end else begin
              state_d = ST_WAIT;
            end
          end else if (pc_write) begin
            pc_d = pc_sel ? br_target : pc_inc;
          end
        end
        ST_WAIT: begin
          if (imem_valid) begin
            ir_d    = imem_rdata;
            pc_d    = pc_inc;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign imem_req    = ir_load | (state_q == ST_WAIT);
  assign imem_addr   = pc_q;
  assign fetch_stall = (state_q == ST_WAIT);
  assign instr       = ir_q;
  assign opcode      = ir_q[31:28];
  assign mm          = ir_q[27:24];
  assign imm         = ir_q[15:0];

`ifdef SISC_BRANCH_COUNT_EN
  logic [15:0] br_cnt_q, br_cnt_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    br_cnt_d    = br_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    if (pc_rst) begin
      br_cnt_d    = '0;
      fetch_cnt_d = '0;
    end else begin
      if (br_upd && br_cnt_q != 16'hFFFF)
        br_cnt_d = br_cnt_q + 16'd1;
      if (capture && fetch_cnt_q != 16'hFFFF)
        fetch_cnt_d = fetch_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      br_cnt_q    <= '0;
      fetch_cnt_q <= '0;
    end else begin
      br_cnt_q    <= br_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign br_taken_cnt = br_cnt_q;
  assign fetch_cnt    = fetch_cnt_q;
`else
  logic unused_br_upd;
  assign unused_br_upd = br_upd;
`endif

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed-vector bench for sisc_fetch_unit; expected values are hand-computed constants.
module tb_sisc_fetch_unit;

  logic        clk;
  logic        rst_f;
  logic        pc_rst;
  logic        pc_write;
  logic        pc_sel;
  logic        br_sel;
  logic        ir_load;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        fetch_stall;
  logic [31:0] instr;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;
`ifdef SISC_BRANCH_COUNT_EN
  logic [15:0] br_taken_cnt;
  logic [15:0] fetch_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  sisc_fetch_unit #(.PC_W(16), .INSTR_W(32)) dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .pc_rst      (pc_rst),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .br_sel      (br_sel),
    .ir_load     (ir_load),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .fetch_stall (fetch_stall),
    .instr       (instr),
    .opcode      (opcode),
    .mm          (mm),
    .imm         (imm)
`ifdef SISC_BRANCH_COUNT_EN
    ,
    .br_taken_cnt(br_taken_cnt),
    .fetch_cnt   (fetch_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0; ir_load = 0; imem_valid = 0;
  endtask

  task automatic fetch_now(input logic [31:0] data);
    idle_in();
    ir_load = 1; imem_valid = 1; imem_rdata = data;
    tick();
    idle_in();
  endtask

  task automatic branch(input logic abs_tgt);
    idle_in();
    pc_write = 1; pc_sel = 1; br_sel = abs_tgt;
    tick();
    idle_in();
  endtask

  initial begin
    rst_f = 0;
    imem_rdata = '0;
    idle_in();
    tick();
    tick();
    check_vec("rst_pc", 32'(imem_addr), 32'h0);
    check_vec("rst_ir", instr, 32'h0);
    check_vec("rst_stall", 32'(fetch_stall), 32'h0);
    check_vec("rst_req", 32'(imem_req), 32'h0);
    rst_f = 1;

    // PC 0 -> 5 by plain increments
    pc_write = 1; pc_sel = 0;
    repeat (5) tick();
    idle_in();
    check_vec("inc_pc5", 32'(imem_addr), 32'h5);

    // zero-wait fetch with a concurrent increment request: one increment only
    ir_load = 1; imem_valid = 1; imem_rdata = 32'h8100_0003; pc_write = 1; pc_sel = 0;
    #1 check_vec("req_comb", 32'(imem_req), 32'h1);
    tick();
    idle_in();
    check_vec("f0_ir", instr, 32'h8100_0003);
    check_vec("f0_pc", 32'(imem_addr), 32'h6);
    check_vec("f0_opc", 32'(opcode), 32'h8);
    check_vec("f0_mm", 32'(mm), 32'h1);
    check_vec("f0_imm", 32'(imm), 32'h3);

    pc_write = 1;
    tick();
    idle_in();

    // wait-state fetch at PC 7; a branch attempt while stalled must be ignored
    ir_load = 1; imem_valid = 0; imem_rdata = 32'h0000_0040;
    tick();
    check_vec("w1_stall", 32'(fetch_stall), 32'h1);
    check_vec("w1_addr", 32'(imem_addr), 32'h7);
    ir_load = 0; pc_write = 1; pc_sel = 1; br_sel = 1;
    tick();
    idle_in();
    check_vec("w2_stall", 32'(fetch_stall), 32'h1);
    check_vec("w2_req", 32'(imem_req), 32'h1);
    check_vec("w2_addr", 32'(imem_addr), 32'h7);
    tick();
    check_vec("w3_stall", 32'(fetch_stall), 32'h1);
    check_vec("w3_ir", instr, 32'h8100_0003);
    imem_valid = 1;
    tick();
    idle_in();
    check_vec("w4_stall", 32'(fetch_stall), 32'h0);
    check_vec("w4_ir", instr, 32'h0000_0040);
    check_vec("w4_pc", 32'(imem_addr), 32'h8);

    // absolute and relative branches
    branch(1'b1);
    check_vec("abs_40", 32'(imem_addr), 32'h40);
    fetch_now(32'h0000_000F);
    check_vec("f_41", 32'(imem_addr), 32'h41);
    branch(1'b1);
    check_vec("abs_0f", 32'(imem_addr), 32'hF);
    fetch_now(32'h0000_FFFC);
    check_vec("f_10", 32'(imem_addr), 32'h10);
    branch(1'b0);
    check_vec("rel_neg", 32'(imem_addr), 32'hC);

    // wrap-around on fetch and on relative branch
    fetch_now(32'h0000_FFFF);
    branch(1'b1);
    check_vec("abs_ffff", 32'(imem_addr), 32'hFFFF);
    fetch_now(32'h0000_FFFD);
    check_vec("wrap_fetch", 32'(imem_addr), 32'h0);
    branch(1'b1);
    fetch_now(32'h0000_0004);
    check_vec("f_fffe", 32'(imem_addr), 32'hFFFE);
    branch(1'b0);
    check_vec("rel_wrap", 32'(imem_addr), 32'h2);
`ifdef SISC_BRANCH_COUNT_EN
    check_vec("br_cnt6", 32'(br_taken_cnt), 32'h6);
    check_vec("fetch_cnt7", 32'(fetch_cnt), 32'h7);
`endif

    // pc_rst beats a simultaneous completed fetch
    pc_rst = 1; ir_load = 1; imem_valid = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    idle_in();
    check_vec("prst_pc", 32'(imem_addr), 32'h0);
    check_vec("prst_ir", instr, 32'h0000_0004);
`ifdef SISC_BRANCH_COUNT_EN
    check_vec("prst_br", 32'(br_taken_cnt), 32'h0);
    check_vec("prst_fc", 32'(fetch_cnt), 32'h0);
`endif

    // pc_rst drops a pending wait-state fetch
    ir_load = 1;
    tick();
    check_vec("pw_stall", 32'(fetch_stall), 32'h1);
    ir_load = 0; pc_rst = 1;
    tick();
    idle_in();
    check_vec("pw_stall0", 32'(fetch_stall), 32'h0);
    check_vec("pw_req0", 32'(imem_req), 32'h0);

    repeat (3) branch(1'b1);
    check_vec("br3_pc", 32'(imem_addr), 32'h4);
`ifdef SISC_BRANCH_COUNT_EN
    check_vec("br3_cnt", 32'(br_taken_cnt), 32'h3);
`endif

    // async reset while stalled; a late valid must not be captured
    ir_load = 1;
    tick();
    check_vec("ar_stall", 32'(fetch_stall), 32'h1);
    #2;
    rst_f = 0; ir_load = 0;
    #1;
    check_vec("ar_pc", 32'(imem_addr), 32'h0);
    check_vec("ar_ir", instr, 32'h0);
    check_vec("ar_opc", 32'(opcode), 32'h0);
    check_vec("ar_stall0", 32'(fetch_stall), 32'h0);
    check_vec("ar_req", 32'(imem_req), 32'h0);
    imem_valid = 1; imem_rdata = 32'h1234_5678;
    tick();
    check_vec("ar_hold_ir", instr, 32'h0);
    rst_f = 1;
    tick();
    check_vec("ar_late_ir", instr, 32'h0);
    check_vec("ar_late_pc", 32'(imem_addr), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
